bus_timer_port: RTL and testbench
=================================

Name: bus_timer_port

Overview:
Memory-mapped bus responder for the cpu6502 next-cycle bus. It decodes a 4-byte register window and services reads and writes with a programmable number of wait states, signalled through ready. It holds a 16-bit prescaled countdown timer and drives the CPU irq/nmi lines. The top level muxes its data_o onto cpu data_i whenever cs is high, in the same way as memory.

Parameters:
BASE, 16'hbff8, window base address (4-byte aligned); registers at BASE+0..BASE+3
WAIT_STATES, 0, ready-low cycles inserted per access (0..15)
PRESCALE, 1, clocks per timer decrement (1..256)

Ports:
clk  input  1  system clock, all state on posedge
reset  input  1  synchronous, active-high
address_next  input  16  CPU address_next
write_next  input  1  CPU write_next
data_next  input  8  CPU data_o_next (write data)
data_o  output  8  registered read data
cs  output  1  high for the cycle in which data_o is the read result for the current CPU address
ready  output  1  registered; low stalls the CPU
irq  output  1  level interrupt request
nmi  output  1  level NMI line (the CPU edge-detects it)

Behaviour:
- sel = (address_next[15:2] == BASE[15:2]); reg index = address_next[1:0].
- Registers:
  - 0 CTRL rw: b0 timer enable, b1 auto-reload, b2 timer-irq enable, b7 nmi level; other bits read 0.
  - 1 STATUS: b0 expired (write 1 clears), b1 soft irq (rw); other bits read 0.
  - 2 RELOAD_LO rw.
  - 3 RELOAD_HI rw. A write to RELOAD_HI also loads count <= {HI_new, LO} and zeroes the prescaler.
- Reset values: ready=1, data_o=0, cs=0, irq=0, nmi=0, CTRL=0, STATUS=0, RELOAD=16'hffff, count=16'hffff, prescaler=0, state IDLE.
- States: IDLE, WAIT.
  - IDLE: on a posedge with sel=1:
    - WAIT_STATES==0: commit the access at this edge.
    - WAIT_STATES>0: latch index/write/data, set ready<=0 and wcnt<=WAIT_STATES-1, go to WAIT.
  - WAIT: bus inputs are ignored. The CPU holds address_next stable while ready=0. On each edge, if wcnt==0, commit the latched access, set ready<=1 and go to IDLE; otherwise wcnt--.
- Commit:
  - Write: update the register.
  - Read: data_o <= register value. cs<=1 for exactly one cycle after the commit edge; otherwise cs<=0.
  - A write never changes data_o and never sets cs.
- Read latency: data valid 1 cycle after commit. Total access time is WAIT_STATES+1 cycles.
- Back-to-back accesses with WAIT_STATES==0 are serviced every cycle.
- Timer:
  - tick = enable && prescaler==PRESCALE-1. The prescaler increments while enable is set and wraps to 0 on tick; it holds while enable is clear.
  - On tick: if count!=0, count--.
  - On tick with count==0: set expired. If auto-reload, count<=RELOAD; else count holds 0 and CTRL.b0<=0.
- Simultaneous events:
  - Expire on the same edge as a write-1-to-clear of expired: set wins.
  - Expire on the same edge as a CTRL write: the CTRL write wins for b0.
  - RELOAD_HI write on the same edge as a tick: the load wins and the tick is discarded.
- irq = registered (expired & irq_en) | soft_irq, updated the edge after the cause.
- nmi = registered CTRL.b7.
- Reset asserted mid-WAIT: the pending access is dropped (no write), ready=1 next cycle, all registers return to their reset values.

Test Plan:
- Reset, WAIT_STATES=0: write 8'h34 to BASE+2, then 8'h12 to BASE+3, then read BASE+3 -> data_o=8'h12 and cs=1 for one cycle; count=16'h1234.
- WAIT_STATES=3: read CTRL -> ready low for exactly 3 cycles after the sel edge; data_o valid with cs=1 on the cycle after ready returns high; no early side effects.
- PRESCALE=1, RELOAD=16'h0003, CTRL=8'h07 -> expired sets 4 ticks after enable; irq=1 one cycle later; count reloads to 3; period of 4 ticks repeats.
- One-shot (CTRL=8'h05) -> after expiry count stays 0 and CTRL reads 8'h04; write 8'h01 to STATUS -> irq=0 next cycle; clear coinciding with expiry -> expired stays 1.
- Write CTRL=8'h80 -> nmi=1 next cycle; write 8'h00 -> nmi=0; write STATUS=8'h02 -> irq=1 with the timer disabled.
- WAIT_STATES=2: write issued, reset asserted during WAIT -> register unchanged, ready=1, outputs at reset values.

Source files
------------

// File: rtl/bus_timer_port.sv
// bus_timer_port: 4-byte memory-mapped responder on the cpu6502 next-cycle
// bus with programmable wait states, a 16-bit prescaled countdown timer and
// registered irq/nmi outputs.
module bus_timer_port #(
   parameter logic [15:0] BASE        = 16'hbff8,
   parameter int unsigned WAIT_STATES = 0,
   parameter int unsigned PRESCALE    = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] address_next,
   input  logic        write_next,
   input  logic [7:0]  data_next,
   output logic [7:0]  data_o,
   output logic        cs,
   output logic        ready,
   output logic        irq,
   output logic        nmi
);

   localparam logic       NO_WAIT = (WAIT_STATES == 0);
   localparam logic [3:0] WS_M1   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
   localparam logic [7:0] PS_M1   = 8'(PRESCALE - 1);

   typedef enum logic {
      S_IDLE,
      S_WAIT
   } state_t;

   state_t      state;
   logic [3:0]  wcnt;
   logic [1:0]  lat_idx;
   logic        lat_wr;
   logic [7:0]  lat_data;

   logic [7:0]  ctrl;
   logic        expired;
   logic        soft_irq;
   logic [15:0] reload;
   logic [15:0] count;
   logic [7:0]  presc;

   logic        sel;
   logic        commit;
   logic [1:0]  acc_idx;
   logic        acc_wr;
   logic [7:0]  acc_data;
   logic [7:0]  rd_val;
   logic        tick;
   logic        hi_wr;
   logic        tick_eff;
   logic        expire;
   logic        ctrl_wr;
   logic        status_wr;

   assign sel = (address_next[15:2] == BASE[15:2]);

   // Pick the access being committed this edge: latched one at the end of
   // WAIT, or the live bus access when no wait states are configured.
   always_comb begin
      commit   = 1'b0;
      acc_idx  = address_next[1:0];
      acc_wr   = write_next;
      acc_data = data_next;
      if (state == S_WAIT) begin
         acc_idx  = lat_idx;
         acc_wr   = lat_wr;
         acc_data = lat_data;
         commit   = (wcnt == 4'd0);
      end else if (sel && NO_WAIT) begin
         commit = 1'b1;
      end
   end

   // Register read mux (unused bits read as 0).
   always_comb begin
      rd_val = '0;
      case (acc_idx)
         2'd0: rd_val = ctrl;
         2'd1: rd_val = {6'd0, soft_irq, expired};
         2'd2: rd_val = reload[7:0];
         2'd3: rd_val = reload[15:8];
         default: rd_val = '0;
      endcase
   end

   assign ctrl_wr   = commit && acc_wr && (acc_idx == 2'd0);
   assign status_wr = commit && acc_wr && (acc_idx == 2'd1);
   assign hi_wr     = commit && acc_wr && (acc_idx == 2'd3);
   assign tick      = ctrl[0] && (presc == PS_M1);
   // A RELOAD_HI load discards a coincident tick entirely.
   assign tick_eff  = tick && !hi_wr;
   assign expire    = tick_eff && (count == 16'd0);

   // Bus handshake FSM with registered ready, cs and read data.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         ready    <= 1'b1;
         data_o   <= '0;
         cs       <= 1'b0;
         wcnt     <= '0;
         lat_idx  <= '0;
         lat_wr   <= 1'b0;
         lat_data <= '0;
      end else begin
         cs <= 1'b0;
         if (commit && !acc_wr) begin
            data_o <= rd_val;
            cs     <= 1'b1;
         end
         case (state)
            S_IDLE: begin
               if (sel && !NO_WAIT) begin
                  lat_idx  <= address_next[1:0];
                  lat_wr   <= write_next;
                  lat_data <= data_next;
                  ready    <= 1'b0;
                  wcnt     <= WS_M1;
                  state    <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (wcnt == 4'd0) begin
                  ready <= 1'b1;
                  state <= S_IDLE;
               end else begin
                  wcnt <= wcnt - 4'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Register file, prescaled timer and interrupt outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl     <= '0;
         expired  <= 1'b0;
         soft_irq <= 1'b0;
         reload   <= '1;
         count    <= '1;
         presc    <= '0;
         irq      <= 1'b0;
         nmi      <= 1'b0;
      end else begin
         if (hi_wr) begin
            presc <= '0;
         end else if (ctrl[0]) begin
            presc <= tick ? 8'd0 : presc + 8'd1;
         end

         if (hi_wr) begin
            count <= {acc_data, reload[7:0]};
         end else if (tick_eff) begin
            if (count != 16'd0) begin
               count <= count - 16'd1;
            end else if (ctrl[1]) begin
               count <= reload;
            end
         end

         // A CTRL write overrides the one-shot auto-disable.
         if (ctrl_wr) begin
            ctrl <= acc_data & 8'h87;
         end else if (expire && !ctrl[1]) begin
            ctrl[0] <= 1'b0;
         end

         // Setting expired wins over a coincident write-1-to-clear.
         if (expire) begin
            expired <= 1'b1;
         end else if (status_wr && acc_data[0]) begin
            expired <= 1'b0;
         end
         if (status_wr) begin
            soft_irq <= acc_data[1];
         end

         if (commit && acc_wr && (acc_idx == 2'd2)) begin
            reload[7:0] <= acc_data;
         end
         if (hi_wr) begin
            reload[15:8] <= acc_data;
         end

         irq <= (expired && ctrl[2]) || soft_irq;
         nmi <= ctrl[7];
      end
   end

endmodule

// File: tb/tb_bus_timer_port.sv
// Randomized self-checking bench for bus_timer_port: three instances with
// different wait-state / prescale settings, compared every cycle against a
// behavioural model, plus directed checks for the key scenarios.
module tb_bus_timer_port;

   localparam logic [15:0] BASE = 16'hbff8;

   int ws[3] = '{0, 3, 2};
   int ps[3] = '{1, 3, 1};

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] addr[3];
   logic        wr[3];
   logic [7:0]  wd[3];
   logic [7:0]  dout[3];
   logic        cs_o[3];
   logic        rdy[3];
   logic        irq_o[3];
   logic        nmi_o[3];

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   // model state
   int m_ctrl[3], m_exp[3], m_soft[3], m_reload[3], m_count[3], m_presc[3];
   int m_busy[3], m_rem[3], m_lidx[3], m_lwr[3], m_ldat[3];
   int e_rdy[3], e_dout[3], e_cs[3], e_irq[3], e_nmi[3];

   always #5 clk = ~clk;

   bus_timer_port #(.BASE(BASE), .WAIT_STATES(0), .PRESCALE(1)) u0 (
      .clk(clk), .reset(reset), .address_next(addr[0]), .write_next(wr[0]),
      .data_next(wd[0]), .data_o(dout[0]), .cs(cs_o[0]), .ready(rdy[0]),
      .irq(irq_o[0]), .nmi(nmi_o[0]));

   bus_timer_port #(.BASE(BASE), .WAIT_STATES(3), .PRESCALE(3)) u1 (
      .clk(clk), .reset(reset), .address_next(addr[1]), .write_next(wr[1]),
      .data_next(wd[1]), .data_o(dout[1]), .cs(cs_o[1]), .ready(rdy[1]),
      .irq(irq_o[1]), .nmi(nmi_o[1]));

   bus_timer_port #(.BASE(BASE), .WAIT_STATES(2), .PRESCALE(1)) u2 (
      .clk(clk), .reset(reset), .address_next(addr[2]), .write_next(wr[2]),
      .data_next(wd[2]), .data_o(dout[2]), .cs(cs_o[2]), .ready(rdy[2]),
      .irq(irq_o[2]), .nmi(nmi_o[2]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock edge of the reference model for instance k.
   function automatic void step(input int k);
      int idx, d, rv, ex_set;
      bit wrt, commit, tick;
      bit sel;
      if (reset) begin
         m_ctrl[k] = 0; m_exp[k] = 0; m_soft[k] = 0;
         m_reload[k] = 16'hffff; m_count[k] = 16'hffff; m_presc[k] = 0;
         m_busy[k] = 0; m_rem[k] = 0;
         e_rdy[k] = 1; e_dout[k] = 0; e_cs[k] = 0; e_irq[k] = 0; e_nmi[k] = 0;
         return;
      end
      sel = (addr[k][15:2] == BASE[15:2]);
      commit = 0; idx = 0; wrt = 0; d = 0;
      if (m_busy[k] != 0) begin
         m_rem[k]--;
         if (m_rem[k] == 0) begin
            commit = 1; idx = m_lidx[k]; wrt = (m_lwr[k] != 0); d = m_ldat[k];
            m_busy[k] = 0;
         end
      end else if (sel) begin
         if (ws[k] == 0) begin
            commit = 1; idx = addr[k][1:0]; wrt = wr[k]; d = wd[k];
         end else begin
            m_busy[k] = 1; m_rem[k] = ws[k];
            m_lidx[k] = addr[k][1:0]; m_lwr[k] = wr[k]; m_ldat[k] = wd[k];
         end
      end
      e_rdy[k] = (m_busy[k] == 0);
      e_irq[k] = ((m_exp[k] & (m_ctrl[k] >> 2)) | m_soft[k]) & 1;
      e_nmi[k] = (m_ctrl[k] >> 7) & 1;
      case (idx)
         0: rv = m_ctrl[k];
         1: rv = m_soft[k] * 2 + m_exp[k];
         2: rv = m_reload[k] % 256;
         default: rv = m_reload[k] / 256;
      endcase
      e_cs[k] = 0;
      if (commit && !wrt) begin
         e_dout[k] = rv; e_cs[k] = 1;
      end
      tick = ((m_ctrl[k] & 1) != 0) && (m_presc[k] == ps[k] - 1);
      if (commit && wrt && idx == 3) tick = 0;
      if ((m_ctrl[k] & 1) != 0)
         m_presc[k] = (m_presc[k] == ps[k] - 1) ? 0 : m_presc[k] + 1;
      ex_set = 0;
      if (tick) begin
         if (m_count[k] > 0) m_count[k]--;
         else begin
            ex_set = 1;
            if ((m_ctrl[k] & 2) != 0) m_count[k] = m_reload[k];
            else m_ctrl[k] = m_ctrl[k] & 8'hfe;
         end
      end
      if (commit && wrt) begin
         case (idx)
            0: m_ctrl[k] = d & 8'h87;
            1: begin
               if ((d & 1) != 0) m_exp[k] = 0;
               m_soft[k] = (d >> 1) & 1;
            end
            2: m_reload[k] = (m_reload[k] & 16'hff00) | d;
            default: begin
               m_reload[k] = (m_reload[k] & 8'hff) | (d * 256);
               m_count[k] = m_reload[k];
               m_presc[k] = 0;
            end
         endcase
      end
      if (ex_set != 0) m_exp[k] = 1;
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) step(k);
   end

   // Continuous comparison of every instance against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 3; k++) begin
            check($sformatf("u%0d.ready", k), rdy[k], e_rdy[k]);
            check($sformatf("u%0d.cs", k), cs_o[k], e_cs[k]);
            check($sformatf("u%0d.data_o", k), dout[k], e_dout[k]);
            check($sformatf("u%0d.irq", k), irq_o[k], e_irq[k]);
            check($sformatf("u%0d.nmi", k), nmi_o[k], e_nmi[k]);
         end
      end
   end

   // Called just after a negedge; returns just after the commit edge.
   task automatic access(input int k, input int idx, input bit w, input int d);
      addr[k] = BASE + 16'(idx); wr[k] = w; wd[k] = 8'(d);
      @(negedge clk);
      for (int i = 0; i < ws[k]; i++) begin
         wd[k] = 8'($urandom);
         @(negedge clk);
      end
      addr[k] = 16'h0000; wr[k] = 1'b0; wd[k] = 8'h00;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         addr[k] = 16'h0000; wr[k] = 1'b0; wd[k] = 8'h00;
      end
      idle(2);
      chk_en = 1'b1;
      check("rst.ready", rdy[0], 1);
      check("rst.data_o", dout[0], 0);
      check("rst.cs", cs_o[0], 0);
      check("rst.irq", irq_o[0], 0);
      reset = 1'b0;
      idle(1);

      // reload load and back-to-back read, no wait states
      access(0, 2, 1, 8'h34);
      access(0, 3, 1, 8'h12);
      access(0, 3, 0, 0);
      check("b2b.data_o", dout[0], 8'h12);
      check("b2b.cs", cs_o[0], 1);
      idle(1);
      check("b2b.cs_drop", cs_o[0], 0);

      // one-shot from 16'h1234
      access(0, 0, 1, 8'h05);
      idle(16'h1235);
      check("oneshot.irq_early", irq_o[0], 0);
      idle(1);
      check("oneshot.irq", irq_o[0], 1);
      access(0, 0, 0, 0);
      check("oneshot.ctrl", dout[0], 8'h04);
      access(0, 1, 1, 8'h01);
      idle(1);
      check("oneshot.irq_clr", irq_o[0], 0);

      // auto-reload with period 4, then clear coinciding with expiry
      access(0, 2, 1, 8'h03);
      access(0, 3, 1, 8'h00);
      access(0, 0, 1, 8'h07);
      idle(4);
      check("auto.irq_early", irq_o[0], 0);
      idle(1);
      check("auto.irq", irq_o[0], 1);
      idle(2);
      access(0, 1, 1, 8'h01);
      idle(1);
      check("auto.set_wins", irq_o[0], 1);

      // nmi and soft irq
      access(0, 0, 1, 8'h80);
      idle(1);
      check("nmi.set", nmi_o[0], 1);
      access(0, 0, 1, 8'h00);
      access(0, 1, 1, 8'h01);
      idle(1);
      check("nmi.clr", nmi_o[0], 0);
      check("irq.clr", irq_o[0], 0);
      access(0, 1, 1, 8'h02);
      idle(1);
      check("soft.irq", irq_o[0], 1);
      access(0, 1, 1, 8'h00);

      // three wait states
      access(1, 0, 1, 8'h86);
      check("ws3.nmi_not_yet", nmi_o[1], 0);
      idle(1);
      check("ws3.nmi", nmi_o[1], 1);
      addr[1] = BASE; wr[1] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("ws3.ready_low%0d", i), rdy[1], 0);
         check($sformatf("ws3.cs_low%0d", i), cs_o[1], 0);
      end
      @(negedge clk);
      addr[1] = 16'h0000;
      check("ws3.ready_back", rdy[1], 1);
      check("ws3.cs", cs_o[1], 1);
      check("ws3.data_o", dout[1], 8'h86);

      // reset during WAIT drops the pending write
      addr[2] = BASE + 16'd2; wr[2] = 1'b1; wd[2] = 8'h55;
      @(negedge clk);
      check("rstw.ready_low", rdy[2], 0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      addr[2] = 16'h0000; wr[2] = 1'b0;
      check("rstw.ready", rdy[2], 1);
      check("rstw.nmi", nmi_o[1], 0);
      access(2, 2, 0, 0);
      check("rstw.reload_lo", dout[2], 8'hff);

      // randomized traffic on all instances
      for (int n = 0; n < 600; n++) begin
         int k, idx, d;
         bit w;
         k   = n % 3;
         idx = $urandom_range(0, 3);
         w   = 1'($urandom);
         d   = $urandom_range(0, 255);
         if (idx == 3) d = $urandom_range(0, 1);
         if (idx == 2) d = $urandom_range(0, 7);
         access(k, idx, w, d);
         idle($urandom_range(0, 2));
      end
      idle(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
